// File: rtl/inst_mem_loader.sv
// Instruction-memory loader: packs a big-endian byte stream into 32-bit words written from address 0
// until the halt word. Optional trailing checksum byte when INST_LOADER_CHKSUM_EN is defined.
module inst_mem_loader #(
    parameter int DEPTH  = 200,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [31:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic              overflow_err,
    output logic [ADDR_W:0]   word_count,
    output logic              chk_err
);

`ifdef INST_LOADER_CHKSUM_EN
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RECV  = 3'd1,
        WRITE = 3'd2,
        CHK   = 3'd3,
        DONE  = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RECV  = 3'd1,
        WRITE = 3'd2,
        DONE  = 3'd4
    } state_t;
`endif

    localparam logic [ADDR_W:0] DEPTH_C   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_C     = (ADDR_W + 1)'(1);
    localparam logic [31:0]     HALT_WORD = 32'hffff_ffff;

    state_t              state_r;
    logic [1:0]          byte_idx_r;
    logic [23:0]         shift_r;
    logic [ADDR_W:0]     count_r;
    logic                rx_ready_r;
    logic                we_r;
    logic [ADDR_W-1:0]   waddr_r;
    logic [31:0]         wdata_r;
    logic                busy_r;
    logic                done_r;
    logic                ovf_r;
    logic                accept_s;
    logic [31:0]         word_s;

`ifdef INST_LOADER_CHKSUM_EN
    logic [7:0]          sum_r;
    logic                chk_r;

    function automatic logic [7:0] chk_add(input logic [7:0] acc, input logic [7:0] data);
        return acc + data;
    endfunction
`endif

    assign accept_s = rx_valid & rx_ready_r;
    // First byte received ends up in the MSB.
    assign word_s   = {shift_r, rx_data};

    // Load sequencer: state, counters and all registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r    <= IDLE;
            byte_idx_r <= 2'd0;
            shift_r    <= 24'd0;
            count_r    <= '0;
            rx_ready_r <= 1'b0;
            we_r       <= 1'b0;
            waddr_r    <= '0;
            wdata_r    <= 32'd0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            ovf_r      <= 1'b0;
`ifdef INST_LOADER_CHKSUM_EN
            sum_r      <= 8'd0;
            chk_r      <= 1'b0;
`endif
        end else begin
            we_r <= 1'b0;
            case (state_r)
                IDLE, DONE: begin
                    if (start) begin
                        byte_idx_r <= 2'd0;
                        shift_r    <= 24'd0;
                        count_r    <= '0;
                        ovf_r      <= 1'b0;
                        done_r     <= 1'b0;
                        busy_r     <= 1'b1;
                        rx_ready_r <= 1'b1;
`ifdef INST_LOADER_CHKSUM_EN
                        sum_r      <= 8'd0;
                        chk_r      <= 1'b0;
`endif
                        state_r    <= RECV;
                    end else begin
                        state_r    <= state_r;
                    end
                end
                RECV: begin
                    if (accept_s) begin
                        shift_r    <= word_s[23:0];
                        byte_idx_r <= byte_idx_r + 2'd1;
`ifdef INST_LOADER_CHKSUM_EN
                        sum_r      <= chk_add(sum_r, rx_data);
`endif
                        if (byte_idx_r == 2'd3) begin
                            rx_ready_r <= 1'b0;
                            // A full memory drops the word and aborts the load.
                            if (count_r == DEPTH_C) begin
                                ovf_r   <= 1'b1;
                                done_r  <= 1'b1;
                                busy_r  <= 1'b0;
                                state_r <= DONE;
                            end else begin
                                we_r    <= 1'b1;
                                waddr_r <= count_r[ADDR_W-1:0];
                                wdata_r <= word_s;
                                state_r <= WRITE;
                            end
                        end else begin
                            state_r <= RECV;
                        end
                    end else begin
                        state_r <= RECV;
                    end
                end
                WRITE: begin
                    count_r <= count_r + ONE_C;
                    if (wdata_r == HALT_WORD) begin
`ifdef INST_LOADER_CHKSUM_EN
                        rx_ready_r <= 1'b1;
                        state_r    <= CHK;
`else
                        done_r     <= 1'b1;
                        busy_r     <= 1'b0;
                        state_r    <= DONE;
`endif
                    end else begin
                        rx_ready_r <= 1'b1;
                        state_r    <= RECV;
                    end
                end
`ifdef INST_LOADER_CHKSUM_EN
                CHK: begin
                    if (accept_s) begin
                        chk_r      <= (rx_data != sum_r);
                        done_r     <= 1'b1;
                        busy_r     <= 1'b0;
                        rx_ready_r <= 1'b0;
                        state_r    <= DONE;
                    end else begin
                        state_r    <= CHK;
                    end
                end
`endif
                default: begin
                    rx_ready_r <= 1'b0;
                    busy_r     <= 1'b0;
                    state_r    <= IDLE;
                end
            endcase
        end
    end

    assign rx_ready     = rx_ready_r;
    assign we           = we_r;
    assign waddr        = waddr_r;
    assign wdata        = wdata_r;
    assign busy         = busy_r;
    assign done         = done_r;
    assign overflow_err = ovf_r;
    assign word_count   = count_r;
`ifdef INST_LOADER_CHKSUM_EN
    assign chk_err      = chk_r;
`else
    assign chk_err      = 1'b0;
`endif

endmodule

// File: tb/tb_inst_mem_loader.sv
// Bench for inst_mem_loader: randomized byte streams checked against a word-level model of the load;
// honours INST_LOADER_CHKSUM_EN for the trailing checksum byte.
module tb_inst_mem_loader;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;
`ifdef INST_LOADER_CHKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              start = 1'b0;
    logic [7:0]        rx_data = 8'd0;
    logic              rx_valid = 1'b0;
    logic              rx_ready;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [31:0]       wdata;
    logic              busy;
    logic              done;
    logic              overflow_err;
    logic [ADDR_W:0]   word_count;
    logic              chk_err;

    inst_mem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rstn(rstn), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .we(we), .waddr(waddr), .wdata(wdata), .busy(busy), .done(done),
        .overflow_err(overflow_err), .word_count(word_count), .chk_err(chk_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model state: one load seen as a list of words and a byte sum.
    int          m_cnt;
    int          m_sum;
    bit          m_done, m_ovf, m_chk, m_await_chk;
    logic [7:0]  m_buf[$];
    bit          exp_we = 1'b0;
    int          exp_waddr;
    logic [31:0] exp_wdata;
    int          last_waddr = 0;
    logic [31:0] last_wdata = 32'd0;
    logic [31:0] wlog[$];
    logic [31:0] prog[$];

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset_load();
        m_cnt = 0; m_sum = 0; m_done = 1'b0; m_ovf = 1'b0; m_chk = 1'b0; m_await_chk = 1'b0;
        m_buf.delete();
        exp_we = 1'b0;
    endfunction

    function automatic void model_reset_all();
        model_reset_load();
        last_waddr = 0;
        last_wdata = 32'd0;
    endfunction

    function automatic void model_accept(input logic [7:0] b);
        logic [31:0] w;
        if (m_await_chk) begin
            m_chk = (b != 8'(m_sum));
            m_await_chk = 1'b0;
            m_done = 1'b1;
            return;
        end
        m_sum = (m_sum + int'(b)) % 256;
        m_buf.push_back(b);
        if (m_buf.size() == 4) begin
            w = {m_buf[0], m_buf[1], m_buf[2], m_buf[3]};
            m_buf.delete();
            if (m_cnt == DEPTH) begin
                m_ovf = 1'b1;
                m_done = 1'b1;
            end else begin
                exp_we = 1'b1;
                exp_waddr = m_cnt;
                exp_wdata = w;
                m_cnt++;
                if (w == 32'hffff_ffff) begin
                    if (CHK_EN) m_await_chk = 1'b1;
                    else m_done = 1'b1;
                end
            end
        end
    endfunction

    // Per-cycle write-port comparison against the model.
    always @(posedge clk) begin
        #2;
        if (rstn) begin
            check("we", 32'(we), 32'(exp_we));
            if (we) wlog.push_back(wdata);
            if (exp_we) begin
                last_waddr = exp_waddr;
                last_wdata = exp_wdata;
            end
            check("waddr", 32'(waddr), 32'(last_waddr));
            check("wdata", wdata, last_wdata);
            check("done_busy_excl", 32'(done & busy), 32'd0);
            exp_we = 1'b0;
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
        rx_valid = 1'b1;
        rx_data = b;
        for (int t = 0; t < 40 && !rx_ready; t++) @(negedge clk);
        if (!rx_ready) begin
            check("rx_ready_timeout", 32'(rx_ready), 32'd1);
            rx_valid = 1'b0;
        end else begin
            model_accept(b);
            @(negedge clk);
            rx_valid = 1'b0;
        end
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        model_reset_load();
        check("start_busy", 32'(busy), 32'd1);
        check("start_rx_ready", 32'(rx_ready), 32'd1);
        check("start_done", 32'(done), 32'd0);
        check("start_wc", 32'(word_count), 32'd0);
        check("start_ovf", 32'(overflow_err), 32'd0);
        check("start_chk", 32'(chk_err), 32'd0);
    endtask

    task automatic run_load(input int gap_max, input int start_at, input int corrupt);
        int nb;
        bit acc;
        nb = 0;
        do_start();
        foreach (prog[i]) begin
            for (int j = 0; j < 4; j++) begin
                if (!m_done) begin
                    send_byte(prog[i][31-8*j -: 8], int'($urandom_range(0, gap_max)));
                    nb++;
                    if (nb == start_at) begin
                        start = 1'b1;
                        @(negedge clk);
                        start = 1'b0;
                    end
                end
            end
        end
        if (m_await_chk) send_byte(8'(m_sum + corrupt), int'($urandom_range(0, gap_max)));
        repeat (3) @(negedge clk);
        check("end_done", 32'(done), 32'(m_done));
        check("end_busy", 32'(busy), 32'd0);
        check("end_ovf", 32'(overflow_err), 32'(m_ovf));
        check("end_wc", 32'(word_count), 32'(m_cnt));
        check("end_chk", 32'(chk_err), 32'(m_chk));
        // Bytes offered after the load must be refused.
        acc = 1'b0;
        rx_valid = 1'b1;
        rx_data = 8'($urandom);
        repeat (6) begin
            @(negedge clk);
            if (rx_ready) acc = 1'b1;
        end
        rx_valid = 1'b0;
        check("no_accept_in_done", 32'(acc), 32'd0);
        check("done_held", 32'(done), 32'd1);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_we"}, 32'(we), 32'd0);
        check({tag, "_waddr"}, 32'(waddr), 32'd0);
        check({tag, "_wdata"}, wdata, 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_ovf"}, 32'(overflow_err), 32'd0);
        check({tag, "_wc"}, 32'(word_count), 32'd0);
        check({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
        check({tag, "_chk"}, 32'(chk_err), 32'd0);
    endtask

    task automatic check_t1(input string tag);
        check({tag, "_nwrites"}, 32'(wlog.size()), 32'd2);
        if (wlog.size() >= 2) begin
            check({tag, "_w0"}, wlog[0], 32'h2001_0003);
            check({tag, "_w1"}, wlog[1], 32'hffff_ffff);
        end
        check({tag, "_wc"}, 32'(word_count), 32'd2);
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_ovf"}, 32'(overflow_err), 32'd0);
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        for (int k = 0; k < 4; k++) w[8*k +: 8] = ($urandom_range(0, 1) == 0) ? 8'hff : 8'($urandom);
        if (w == 32'hffff_ffff) w[7:0] = 8'hfe;
        return w;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        #3;
        check_outputs_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        model_reset_all();

        // Basic two-word program, no gaps.
        prog = '{32'h2001_0003, 32'hffff_ffff};
        wlog.delete();
        run_load(0, 0, 0);
        check_t1("t1");
        if (CHK_EN) begin
            check("t6_model_sum", 32'(m_sum), 32'h20);
            check("t6_chk_ok", 32'(chk_err), 32'd0);
        end

        // Same stream with valid gaps.
        wlog.delete();
        run_load(5, 0, 0);
        check_t1("t2");

        // Start pulse in the middle of a word is ignored.
        wlog.delete();
        run_load(0, 2, 0);
        check_t1("t4");

        // Five non-halt words overflow a 4-word memory.
        prog = '{32'h0102_0304, 32'h11ff_2233, 32'hffff_ff00, 32'h00ff_ffff, 32'h5566_7788, 32'hffff_ffff};
        wlog.delete();
        run_load(1, 0, 0);
        check("t3_ovf", 32'(overflow_err), 32'd1);
        check("t3_wc", 32'(word_count), 32'd4);
        check("t3_nwrites", 32'(wlog.size()), 32'd4);

        // Wrong checksum byte.
        if (CHK_EN) begin
            prog = '{32'h2001_0003, 32'hffff_ffff};
            run_load(0, 0, 1);
            check("t6_chk_bad", 32'(chk_err), 32'd1);
            check("t6_done", 32'(done), 32'd1);
        end

        // Reset in the middle of a load, then a clean reload.
        prog = '{32'h2001_0003, 32'hffff_ffff};
        do_start();
        for (int k = 0; k < 6; k++) send_byte(prog[k / 4][31-8*(k%4) -: 8], 0);
        rstn = 1'b0;
        #1;
        check_outputs_zero("t5");
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        model_reset_all();
        wlog.delete();
        run_load(2, 0, 0);
        check_t1("t5_reload");

        // Random programs, gaps, stray start pulses and checksum errors.
        for (int it = 0; it < 40; it++) begin
            prog.delete();
            for (int n = int'($urandom_range(0, 5)); n > 0; n--) prog.push_back(rand_word());
            prog.push_back(32'hffff_ffff);
            run_load(int'($urandom_range(0, 3)), int'($urandom_range(0, 8)), int'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
